// File: rtl/brew_timer_if.sv
// Control/status bundle for brew_timer: operator inputs in, countdown status out.
interface brew_timer_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             abort;
    logic             pause;
    logic [1:0]       sel;
    logic [CNT_W-1:0] remaining;
    logic             running;
    logic             expired;
    logic             done;
    logic             blink;

    modport master (
        output start, abort, pause, sel,
        input  remaining, running, expired, done, blink
    );

    modport slave (
        input  start, abort, pause, sel,
        output remaining, running, expired, done, blink
    );
endinterface

// File: rtl/brew_timer.sv
// Preset countdown timer with tick prescaler, blink output and expiry pulse.
// Optional PAUSE state is compiled in when BREW_TIMER_PAUSE_EN is defined.
module brew_timer #(
    parameter int CLK_HZ  = 100000000,
    parameter int TICK_HZ = 1,
    parameter int CNT_W   = 8,
    parameter int T0      = 30,
    parameter int T1      = 45,
    parameter int T2      = 60,
    parameter int T3      = 90
) (
    input  logic         clk,
    input  logic         rst_n,
    brew_timer_if.slave  bus
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] HALF = PW'(DIV / 2);

`ifdef BREW_TIMER_PAUSE_EN
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

    state_t           state, state_n;
    logic [PW-1:0]    presc, presc_n;
    logic [CNT_W-1:0] rem, rem_n;
    logic [CNT_W-1:0] preset;
    logic             expired_q, exp_n;
    logic             start_q;
    logic             start_ev;
    logic             tick;

    assign start_ev = bus.start & ~start_q;
    assign tick     = (state == RUN) && (presc == LAST);

    always_comb begin
        case (bus.sel)
            2'd0:    preset = CNT_W'(T0);
            2'd1:    preset = CNT_W'(T1);
            2'd2:    preset = CNT_W'(T2);
            default: preset = CNT_W'(T3);
        endcase
    end

    // Priority: abort, then start event, then tick, then pause.
    always_comb begin
        state_n = state;
        presc_n = presc;
        rem_n   = rem;
        exp_n   = 1'b0;
        if (bus.abort) begin
            state_n = IDLE;
            presc_n = '0;
            rem_n   = '0;
        end else if (start_ev) begin
            presc_n = '0;
            rem_n   = preset;
            if (preset == '0) begin
                state_n = DONE;
                exp_n   = 1'b1;
            end else begin
                state_n = RUN;
            end
        end else begin
            case (state)
                RUN: begin
                    if (tick) begin
                        presc_n = '0;
                        if (rem <= CNT_W'(1)) begin
                            rem_n   = '0;
                            state_n = DONE;
                            exp_n   = 1'b1;
                        end else begin
                            rem_n = rem - CNT_W'(1);
                        end
                    end else begin
                        presc_n = presc + PW'(1);
                    end
`ifdef BREW_TIMER_PAUSE_EN
                    // The cycle that requests a pause still counts; freezing starts in PAUSE.
                    if (bus.pause && state_n == RUN) state_n = PAUSE;
`endif
                end
`ifdef BREW_TIMER_PAUSE_EN
                PAUSE: begin
                    if (!bus.pause) state_n = RUN;
                end
`endif
                default: ;
            endcase
        end
    end

`ifndef BREW_TIMER_PAUSE_EN
    logic unused_pause;
    assign unused_pause = bus.pause;
`endif

    // start_q resets high so a start level held through reset is not an event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            presc     <= '0;
            rem       <= '0;
            expired_q <= 1'b0;
            start_q   <= 1'b1;
        end else begin
            state     <= state_n;
            presc     <= presc_n;
            rem       <= rem_n;
            expired_q <= exp_n;
            start_q   <= bus.start;
        end
    end

    assign bus.remaining = rem;
    assign bus.expired   = expired_q;
    assign bus.done      = (state == DONE);
    assign bus.blink     = (state == RUN) && (presc < HALF);
`ifdef BREW_TIMER_PAUSE_EN
    assign bus.running   = (state == RUN) || (state == PAUSE);
`else
    assign bus.running   = (state == RUN);
`endif
endmodule

// File: tb/tb_brew_timer.sv
// Directed bench for brew_timer (CLK_HZ=10, TICK_HZ=1 -> 10 clocks per tick).
// A cycle-level reference model is compared every cycle; literal checks pin key points.
module tb_brew_timer;
    localparam int DIV = 10;
    localparam int PRE [4] = '{30, 45, 60, 90};
`ifdef BREW_TIMER_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   exp_seen = 0;

    brew_timer_if #(.CNT_W(8)) bus ();
    brew_timer_if #(.CNT_W(8)) bz ();

    brew_timer #(.CLK_HZ(10), .TICK_HZ(1), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    brew_timer #(.CLK_HZ(10), .TICK_HZ(1), .CNT_W(8), .T2(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .bus(bz)
    );

    always #5 clk = ~clk;

    // Reference model: mode, ticks left, and clocks spent in RUN since the last tick.
    int m_mode = M_IDLE, m_rem = 0, m_ph = 0;
    bit m_exp = 1'b0, m_sq = 1'b1;
    int n_mode, n_rem, n_ph;
    bit n_exp;

    always_comb begin
        n_mode = m_mode;
        n_rem  = m_rem;
        n_ph   = m_ph;
        n_exp  = 1'b0;
        if (bus.abort) begin
            n_mode = M_IDLE; n_rem = 0; n_ph = 0;
        end else if (bus.start && !m_sq) begin
            n_rem = PRE[bus.sel];
            n_ph  = 0;
            if (n_rem == 0) begin n_mode = M_DONE; n_exp = 1'b1; end
            else n_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (m_ph == DIV - 1) begin
                n_ph  = 0;
                n_rem = m_rem - 1;
                if (n_rem == 0) begin n_mode = M_DONE; n_exp = 1'b1; end
            end else begin
                n_ph = m_ph + 1;
            end
            if (PAUSE_EN && bus.pause && n_mode == M_RUN) n_mode = M_PAUSE;
        end else if (m_mode == M_PAUSE && !bus.pause) begin
            n_mode = M_RUN;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= M_IDLE; m_rem <= 0; m_ph <= 0; m_exp <= 1'b0; m_sq <= 1'b1;
        end else begin
            m_mode <= n_mode; m_rem <= n_rem; m_ph <= n_ph; m_exp <= n_exp; m_sq <= bus.start;
        end
    end

    task automatic chk(input string nm, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    task automatic monitor();
        bit e_run, e_blink, e_done;
        forever begin
            @(negedge clk);
            e_run   = (m_mode == M_RUN) || (m_mode == M_PAUSE);
            e_blink = (m_mode == M_RUN) && (m_ph < DIV / 2);
            e_done  = (m_mode == M_DONE);
            n_tests++;
            if (bus.remaining !== 8'(m_rem) || bus.running !== e_run || bus.expired !== m_exp ||
                bus.done !== e_done || bus.blink !== e_blink) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t rem %0d/%0d run %b/%b exp %b/%b done %b/%b blink %b/%b",
                         $time, bus.remaining, m_rem, bus.running, e_run, bus.expired, m_exp,
                         bus.done, e_done, bus.blink, e_blink);
            end
            if (bus.expired === 1'b1) exp_seen++;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Start edge with preset s; returns just after the loading edge with start low again.
    task automatic fire(input logic [1:0] s);
        bus.sel   = s;
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
    endtask

    task automatic wait_exp(input int limit, output int idx);
        idx = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (bus.expired === 1'b1) begin idx = i; break; end
        end
        #1;
    endtask

    initial begin
        int idx, base;
        bus.start = 1'b0; bus.abort = 1'b0; bus.pause = 1'b0; bus.sel = 2'd0;
        bz.start  = 1'b0; bz.abort  = 1'b0; bz.pause  = 1'b0; bz.sel  = 2'd0;
        step(3);
        rst_n = 1'b1;
        fork monitor(); join_none
        step(1);
        chk("reset_rem", int'(bus.remaining), 0);
        chk("reset_running", int'(bus.running), 0);
        chk("reset_done", int'(bus.done), 0);
        chk("reset_blink", int'(bus.blink), 0);

        // Full T0 countdown: expiry 300 clocks after load.
        base = exp_seen;
        fire(2'd0);
        chk("t0_load_rem", int'(bus.remaining), 30);
        chk("t0_load_blink", int'(bus.blink), 1);
        wait_exp(400, idx);
        chk("t0_expiry_cycle", idx, 300);
        chk("t0_done", int'(bus.done), 1);
        chk("t0_rem_zero", int'(bus.remaining), 0);
        step(5);
        chk("t0_expired_low", int'(bus.expired), 0);
        chk("t0_pulse_count", exp_seen - base, 1);

        // Abort in the cycle of tick 5 of T1.
        base = exp_seen;
        fire(2'd1);
        step(49);
        chk("abort_pre_rem", int'(bus.remaining), 41);
        bus.abort = 1'b1;
        step(1);
        bus.abort = 1'b0;
        chk("abort_rem", int'(bus.remaining), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_running", int'(bus.running), 0);
        step(100);
        chk("abort_no_pulse", exp_seen - base, 0);

        // Restart mid-count at remaining=12 with sel=3.
        fire(2'd0);
        step(183);
        chk("restart_pre_rem", int'(bus.remaining), 12);
        fire(2'd3);
        chk("restart_rem", int'(bus.remaining), 90);
        step(9);
        chk("restart_hold", int'(bus.remaining), 90);
        step(1);
        chk("restart_first_tick", int'(bus.remaining), 89);

        // Pause for 25 clocks starting at prescaler 5.
        fire(2'd0);
        step(55);
        chk("pause_pre_rem", int'(bus.remaining), 25);
        bus.pause = 1'b1;
        step(25);
        chk("pause_rem", int'(bus.remaining), PAUSE_EN ? 25 : 22);
        chk("pause_running", int'(bus.running), 1);
        chk("pause_blink", int'(bus.blink), PAUSE_EN ? 0 : 1);
        bus.pause = 1'b0;
        wait_exp(400, idx);
        chk("pause_expiry_cycle", idx + 80, PAUSE_EN ? 325 : 300);

        // Zero preset: straight to DONE with a single expired pulse.
        bz.sel   = 2'd2;
        bz.start = 1'b1;
        step(1);
        bz.start = 1'b0;
        chk("zero_done", int'(bz.done), 1);
        chk("zero_expired", int'(bz.expired), 1);
        chk("zero_running", int'(bz.running), 0);
        chk("zero_rem", int'(bz.remaining), 0);
        step(1);
        chk("zero_expired_low", int'(bz.expired), 0);
        chk("zero_done_hold", int'(bz.done), 1);

        // Reset mid-RUN with start held high; no restart until start re-rises.
        fire(2'd3);
        step(20);
        bus.start = 1'b1;
        step(5);
        chk("rst_pre_running", int'(bus.running), 1);
        rst_n = 1'b0;
        step(1);
        chk("rst_rem", int'(bus.remaining), 0);
        chk("rst_running", int'(bus.running), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_blink", int'(bus.blink), 0);
        chk("rst_expired", int'(bus.expired), 0);
        step(2);
        rst_n = 1'b1;
        step(20);
        chk("rst_held_rem", int'(bus.remaining), 0);
        chk("rst_held_running", int'(bus.running), 0);
        bus.start = 1'b0;
        step(1);
        bus.start = 1'b1;
        step(1);
        chk("rst_restart_rem", int'(bus.remaining), 90);
        chk("rst_restart_running", int'(bus.running), 1);
        bus.start = 1'b0;
        step(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/brew_timer.md
BREW_TIMER -- requirements
Module: brew_timer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 1, countdown tick rate in Hz; DIV = CLK_HZ/TICK_HZ, DIV >= 2.
REQ-003 SHALL have parameter CNT_W, default 8, width of the remaining-ticks counter.
REQ-004 SHALL have parameters T0, T1, T2, T3, defaults 30, 45, 60, 90, preset durations in ticks, each < 2^CNT_W.
REQ-005 SHALL have port clk, input, 1, single system clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, debounced start level; its rising edge is the start event.
REQ-008 SHALL have port abort, input, 1, synchronous cancel, active high.
REQ-009 SHALL have port pause, input, 1, hold countdown while high (see Configuration).
REQ-010 SHALL have port sel, input, 2, preset select: 0->T0, 1->T1, 2->T2, 3->T3.
REQ-011 SHALL have port remaining, output, CNT_W, ticks left.
REQ-012 SHALL have port running, output, 1, high in RUN and PAUSE.
REQ-013 SHALL have port expired, output, 1, one-cycle pulse at countdown end.
REQ-014 SHALL have port done, output, 1, level, high in DONE.
REQ-015 SHALL have port blink, output, 1, tick-rate square wave, valid only in RUN.

Function
REQ-016 SHALL register start once (start_q); start event = start & ~start_q.
REQ-017 SHALL implement states IDLE, RUN, PAUSE, DONE.
REQ-018 SHALL, on a start event in any state, load remaining with preset[sel], clear the prescaler and enter RUN on the next edge: 1-cycle latency.
REQ-019 SHALL, when preset[sel] = 0, enter DONE directly and assert expired for that single cycle.
REQ-020 SHALL, in RUN, count the prescaler 0..DIV-1 and wrap; a tick occurs in the cycle where the prescaler = DIV-1.
REQ-021 SHALL decrement remaining by 1 on each tick; on a tick with remaining = 1: remaining -> 0, state -> DONE, expired = 1 for exactly one cycle.
REQ-022 SHALL hold remaining at 0 in DONE; SHALL never underflow or wrap.
REQ-023 SHALL, on abort = 1, force IDLE and remaining = 0, clear the prescaler, and assert no expired pulse.
REQ-024 SHALL give priority abort > start event > tick > pause in the same cycle.
REQ-025 SHALL drive blink = 1 while in RUN with prescaler < DIV/2, otherwise 0.
REQ-026 SHALL keep remaining at its last value in IDLE, except as stated in REQ-023 and REQ-028.
REQ-027 SHALL ignore a start level held high across reset until it falls and rises again.

Reset
REQ-028 SHALL, with rst_n = 0, asynchronously set state = IDLE, prescaler = 0, start_q = 1, remaining = 0, running = 0, expired = 0, done = 0, blink = 0.
REQ-029 SHALL, on reset mid-countdown, discard the count with no expired pulse; operation resumes on the first clk edge after rst_n rises.

Configuration
REQ-030 SHALL honour the macro BREW_TIMER_PAUSE_EN.
REQ-031 SHALL, when BREW_TIMER_PAUSE_EN is defined: pause = 1 in RUN moves to PAUSE on the next edge; PAUSE freezes the prescaler and remaining, keeps running = 1 and blink = 0; pause = 0 returns to RUN and counting resumes from the frozen prescaler value.
REQ-032 SHALL, when BREW_TIMER_PAUSE_EN is undefined, omit the PAUSE state; the pause port is present but ignored.

Verification (CLK_HZ=10, TICK_HZ=1, DIV=10, CNT_W=8)
REQ-033 SHALL cover: sel=0 (T0=30), start edge at cycle 0 -> remaining=30 at cycle 1; expired pulse once, 300 cycles after entering RUN; remaining=0; done=1.
REQ-034 SHALL cover: abort at tick 5 of T1 -> IDLE, remaining=0, expired never pulses, done=0.
REQ-035 SHALL cover: second start edge at remaining=12 with sel=3 -> remaining=90 next cycle, prescaler=0.
REQ-036 SHALL cover: with PAUSE_EN, pause high for 25 cycles mid-count -> remaining frozen; expiry delayed by exactly 25 cycles; without PAUSE_EN, no delay.
REQ-037 SHALL cover: T2 overridden to 0, sel=2, start -> done=1 and one expired pulse, with no RUN cycle.
REQ-038 SHALL cover: rst_n low for 3 cycles mid-RUN with start held high -> all outputs 0; no restart until start falls and rises again.
